// File: rtl/nco_sweep_if.sv
// Control/status bundle between a sweep controller and the nco_sweep sequencer.
interface nco_sweep_if #(
  parameter int unsigned FW = 16,
  parameter int unsigned DW = 24
);
  logic          start;
  logic          stop;
  logic [FW-1:0] f_start;
  logic [FW-1:0] f_stop;
  logic [FW-1:0] f_step;
  logic [DW-1:0] dwell;
  logic          mode;
  logic [FW-1:0] freq;
  logic          nco_en;
  logic          busy;
  logic          step_stb;
  logic          done;

  modport master (
    output start, stop, f_start, f_stop, f_step, dwell, mode,
    input  freq, nco_en, busy, step_stb, done
  );

  modport slave (
    input  start, stop, f_start, f_stop, f_step, dwell, mode,
    output freq, nco_en, busy, step_stb, done
  );
endinterface

// File: rtl/nco_sweep.sv
// Frequency-sweep sequencer driving the NCO tuning word and enable.
// Single sweep or continuous triangle chirp between two latched endpoints.
module nco_sweep (
  input  logic       clk,
  input  logic       rst,
  nco_sweep_if.slave bus
);
  localparam int unsigned FW = 16;
  localparam int unsigned DW = 24;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] freq_q, freq_nxt;
  logic [FW-1:0] origin_q, origin_nxt;
  logic [FW-1:0] target_q, target_nxt;
  logic [FW-1:0] step_q, step_nxt;
  logic [DW-1:0] dwell_m1_q, dwell_m1_nxt;
  logic [DW-1:0] cnt_q, cnt_nxt;
  logic          up_q, up_nxt;
  logic          mode_q, mode_nxt;
  logic          stb_q, stb_nxt;
  logic          busy_q, busy_nxt;
  logic          nco_en_q, nco_en_nxt;
  logic          done_q, done_nxt;
  logic [FW-1:0] stepped;

  // One step from cur toward tgt, evaluated one bit wider so it clamps instead of wrapping.
  function automatic logic [FW-1:0] step_toward(
    input logic [FW-1:0] cur,
    input logic [FW-1:0] tgt,
    input logic [FW-1:0] inc,
    input logic          up
  );
    logic [FW:0]   wide;
    logic [FW-1:0] res;
    if (up) begin
      wide = {1'b0, cur} + {1'b0, inc};
      res  = (wide > {1'b0, tgt}) ? tgt : wide[FW-1:0];
    end else begin
      wide = {1'b0, cur} - {1'b0, inc};
      res  = (wide[FW] || (wide[FW-1:0] < tgt)) ? tgt : wide[FW-1:0];
    end
    return res;
  endfunction

  always_comb begin
    state_nxt    = state;
    freq_nxt     = freq_q;
    origin_nxt   = origin_q;
    target_nxt   = target_q;
    step_nxt     = step_q;
    dwell_m1_nxt = dwell_m1_q;
    cnt_nxt      = cnt_q;
    up_nxt       = up_q;
    mode_nxt     = mode_q;
    stb_nxt      = 1'b0;
    stepped      = freq_q;

    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          origin_nxt   = bus.f_start;
          target_nxt   = bus.f_stop;
          step_nxt     = (bus.f_step == '0) ? FW'(1) : bus.f_step;
          dwell_m1_nxt = (bus.dwell == '0) ? '0 : bus.dwell - DW'(1);
          cnt_nxt      = (bus.dwell == '0) ? '0 : bus.dwell - DW'(1);
          up_nxt       = (bus.f_stop >= bus.f_start);
          mode_nxt     = bus.mode;
          freq_nxt     = bus.f_start;
          stb_nxt      = 1'b1;
          state_nxt    = SWEEP;
        end
      end

      SWEEP: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (cnt_q != '0) begin
          cnt_nxt = cnt_q - DW'(1);
        end else if (freq_q != target_q) begin
          stepped  = step_toward(freq_q, target_q, step_q, up_q);
          freq_nxt = stepped;
          cnt_nxt  = dwell_m1_q;
          stb_nxt  = 1'b1;
        end else if (!mode_q) begin
          state_nxt = DONE;
        end else begin
          // Reversal: swap endpoints and step toward the old origin in the same cycle.
          origin_nxt = target_q;
          target_nxt = origin_q;
          up_nxt     = !up_q;
          stepped    = step_toward(freq_q, origin_q, step_q, !up_q);
          freq_nxt   = stepped;
          cnt_nxt    = dwell_m1_q;
          stb_nxt    = (stepped != freq_q);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt   = (state_nxt == SWEEP);
    nco_en_nxt = (state_nxt == SWEEP);
    done_nxt   = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      freq_q     <= '0;
      origin_q   <= '0;
      target_q   <= '0;
      step_q     <= '0;
      dwell_m1_q <= '0;
      cnt_q      <= '0;
      up_q       <= 1'b0;
      mode_q     <= 1'b0;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      nco_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      freq_q     <= freq_nxt;
      origin_q   <= origin_nxt;
      target_q   <= target_nxt;
      step_q     <= step_nxt;
      dwell_m1_q <= dwell_m1_nxt;
      cnt_q      <= cnt_nxt;
      up_q       <= up_nxt;
      mode_q     <= mode_nxt;
      stb_q      <= stb_nxt;
      busy_q     <= busy_nxt;
      nco_en_q   <= nco_en_nxt;
      done_q     <= done_nxt;
    end
  end

  assign bus.freq     = freq_q;
  assign bus.nco_en   = nco_en_q;
  assign bus.busy     = busy_q;
  assign bus.step_stb = stb_q;
  assign bus.done     = done_q;
endmodule

// File: doc/nco_sweep.md
# nco_sweep

Frequency-sweep sequencer that drives the tuning-word and enable inputs of the NCO. It steps the 16-bit frequency word from a start value to a stop value in fixed increments, holding each value for a programmable dwell time. It supports a single sweep or a continuous triangle (up/down) chirp. The NCO's sine output then goes to the 8-bit pin DAC as before.

## Interface
- FW, 16, frequency-word width; matches the NCO frequency input.
- DW, 24, dwell-counter width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a sweep.
- stop  in  1  one-cycle pulse that aborts a sweep.
- f_start  in  FW  first frequency word.
- f_stop  in  FW  end frequency word.
- f_step  in  FW  increment magnitude; 0 is treated as 1.
- dwell  in  DW  clk cycles per step; 0 is treated as 1.
- mode  in  1  0 = single sweep, 1 = continuous triangle.
- freq  out  FW  frequency word to the NCO.
- nco_en  out  1  NCO enable.
- busy  out  1  high while a sweep is active.
- step_stb  out  1  one-cycle pulse in the same cycle that freq takes a new value.
- done  out  1  one-cycle pulse when a single sweep completes.

## Operation
- States: IDLE, SWEEP, DONE.
- Reset: state IDLE; freq=0, nco_en=0, busy=0, step_stb=0, done=0; dwell counter cleared.
- IDLE, on start (and no stop in the same cycle):
  - Latch f_start, f_stop, f_step, dwell and mode into shadow registers.
  - Set direction: up if f_stop >= f_start, else down.
  - Go to SWEEP.
- IDLE: freq holds its last value; nco_en=0.
- Input changes while busy have no effect; only the latched copies are used.
- SWEEP, dwell counter loads dwell-1 on each step and counts down. On expiry:
  - freq != endpoint: next = freq ± f_step, computed in FW+1 bits and clamped to the endpoint (never wraps).
  - freq == endpoint, mode 0: go to DONE.
  - freq == endpoint, mode 1: swap endpoints, reverse direction, take one step toward the new endpoint.
- DONE: lasts one cycle; done=1, busy=0, nco_en=0; freq holds the final endpoint; then IDLE.
- stop in any state: go to IDLE next cycle; nco_en=0, busy=0, no done pulse, freq holds. stop wins over a simultaneous start.
- start while busy: ignored.
- f_start == f_stop:
  - mode 0: hold one dwell period, then done.
  - mode 1: hold until stop; step_stb fires only at entry.
- rst mid-sweep: reset values next cycle; no done pulse.

## Timing
- start sampled at edge T. At T+1: freq=f_start, nco_en=1, busy=1, step_stb=1.
- Step k becomes visible at T+1+k·dwell, with step_stb high in that cycle.
- Endpoint reached at step n: done is high at T+1+(n+1)·dwell, and busy and nco_en are low from that same cycle.
- In continuous mode, endpoint reversal produces the next value exactly one dwell after the endpoint, with no extra cycle.
- stop at edge S: busy=0 and nco_en=0 at S+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Up sweep: f_start=100, f_stop=130, f_step=10, dwell=4, mode=0, start at T → freq 100/110/120/130 at T+1/T+5/T+9/T+13; done at T+17; exactly 4 step_stb pulses.
- Clamp: 100→125, f_step=10, dwell=2 → freq 100, 110, 120, 125; no value above 125.
- Down sweep near zero: 20→0, f_step=7, dwell=1 → freq 20, 13, 6, 0, then done; no wrap to 0xFFF9.
- Triangle: 10↔30, f_step=10, dwell=3, mode=1 → freq 10, 20, 30, 20, 10, 20, … every 3 cycles; busy stays high; done never pulses.
- Abort: stop after the second step → busy=0 and nco_en=0 next cycle, freq frozen at 110, no done. start+stop in the same cycle while idle → stays idle.
- Degenerate and reset:
  - dwell=0, f_step=0, 5→8 → freq 5, 6, 7, 8 on consecutive cycles.
  - rst asserted mid-sweep → all outputs 0 next cycle.
  - start pulse while busy → ignored.
